// File: rtl/reg_addr_pkg.sv
// Shared types for the register-address sequencer: instruction classes, FSM states
// and the ARM-state class decoder for the 28-bit (condition-stripped) instruction.
package reg_addr_pkg;

    typedef enum logic [3:0] {
        IC_NONE    = 4'd0,
        IC_MUL     = 4'd1,
        IC_MULL    = 4'd2,
        IC_SWP     = 4'd3,
        IC_BX      = 4'd4,
        IC_HDT_REG = 4'd5,
        IC_HDT_IMM = 4'd6,
        IC_DP      = 4'd7,
        IC_UNDEF   = 4'd8,
        IC_SDT     = 4'd9,
        IC_BDT     = 4'd10,
        IC_BR      = 4'd11,
        IC_SWI     = 4'd12
    } iclass_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BLOCK  = 2'd2
    } state_e;

    localparam int unsigned R_PC = 15;

    // Earlier tests win: the multiply/swap/BX encodings overlap the data-processing space.
    function automatic iclass_e decode_class(input logic [27:0] ins);
        if (ins[27:22] == 6'b000000 && ins[7:4] == 4'b1001)
            return IC_MUL;
        if (ins[27:23] == 5'b00001 && ins[7:4] == 4'b1001)
            return IC_MULL;
        if (ins[27:23] == 5'b00010 && ins[21:20] == 2'b00 && ins[11:4] == 8'b0000_1001)
            return IC_SWP;
        if (ins[27:4] == 24'h12FFF1)
            return IC_BX;
        if (ins[27:25] == 3'b000 && !ins[22] && ins[11:7] == 5'b00001 && ins[4])
            return IC_HDT_REG;
        if (ins[27:25] == 3'b000 && ins[22] && ins[7] && ins[4])
            return IC_HDT_IMM;
        if (ins[27:26] == 2'b00)
            return IC_DP;
        if (ins[27:25] == 3'b011 && ins[4])
            return IC_UNDEF;
        if (ins[27:26] == 2'b01)
            return IC_SDT;
        if (ins[27:25] == 3'b100)
            return IC_BDT;
        if (ins[27:25] == 3'b101)
            return IC_BR;
        if (ins[27:24] == 4'b1111)
            return IC_SWI;
        return IC_NONE;
    endfunction

endpackage

// File: rtl/lsb_encoder.sv
// Lowest-set-bit search over a register list: binary index, one-hot mask, empty flag.
module lsb_encoder #(
    parameter int LIST_W = 16,
    parameter int RA_W   = 4
) (
    input  logic [LIST_W-1:0] list_i,
    output logic [RA_W-1:0]   idx_o,
    output logic [LIST_W-1:0] onehot_o,
    output logic              zero_o
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx_o = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list_i[i]) idx_o = RA_W'(i);
        end
    end

    assign onehot_o = list_i & (~list_i + LIST_W'(1));
    assign zero_o   = ~|list_i;

endmodule

// File: rtl/reg_addr_sequencer.sv
// Turns one accepted instruction into one or more rn/rm/rs read-port beats;
// block transfers emit one beat per set bit of the register list.
module reg_addr_sequencer
    import reg_addr_pkg::*;
#(
    parameter int RA_W    = 4,
    parameter int LIST_W  = 16,
    parameter int INSTR_W = 28
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RA_W-1:0]    rn,
    output logic [RA_W-1:0]    rm,
    output logic [RA_W-1:0]    rs,
    output logic               out_last,
    output logic [3:0]         iclass
);

    state_e              state_q, state_d;
    iclass_e             iclass_q, iclass_d, dec_class;
    logic [RA_W-1:0]     rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
    logic [RA_W-1:0]     dec_rn, dec_rm, dec_rs;
    logic [LIST_W-1:0]   list_q, list_d;
    logic [RA_W-1:0]     enc_idx;
    logic [LIST_W-1:0]   enc_onehot;
    logic                enc_zero;
    logic                accept;

    function automatic logic [RA_W-1:0] ra(input logic [3:0] f);
        return RA_W'(f);
    endfunction

    lsb_encoder #(.LIST_W(LIST_W), .RA_W(RA_W)) u_lsb (
        .list_i   (list_q),
        .idx_o    (enc_idx),
        .onehot_o (enc_onehot),
        .zero_o   (enc_zero)
    );

    always_comb begin
        dec_class = decode_class(instruction[27:0]);
        dec_rn    = '0;
        dec_rm    = '0;
        dec_rs    = '0;
        unique case (dec_class)
            IC_MUL:                 begin dec_rn = ra(instruction[15:12]); dec_rm = ra(instruction[3:0]); dec_rs = ra(instruction[11:8]); end
            IC_MULL:                begin dec_rn = ra(instruction[11:8]);  dec_rm = ra(instruction[3:0]); end
            IC_SWP:                 begin dec_rn = ra(instruction[19:16]); dec_rm = ra(instruction[3:0]); end
            IC_BX:                  dec_rn = ra(instruction[3:0]);
            IC_HDT_REG, IC_HDT_IMM: begin dec_rn = ra(instruction[19:16]); dec_rm = ra(instruction[3:0]); dec_rs = ra(instruction[15:12]); end
            IC_DP:                  begin dec_rn = ra(instruction[19:16]); dec_rm = ra(instruction[3:0]); dec_rs = ra(instruction[11:8]); end
            IC_SDT:                 begin dec_rn = ra(instruction[19:16]); dec_rs = ra(instruction[15:12]); end
            IC_BDT:                 dec_rn = ra(instruction[19:16]);
            IC_BR:                  dec_rn = RA_W'(R_PC);
            default:                ;
        endcase
    end

    // Ready also opens on the final consumed beat so instructions stream without a bubble.
    assign instr_ready = reset_n && !flush &&
                         (state_q == ST_IDLE || (out_valid && out_last && out_ready));
    assign accept      = instr_valid && instr_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            iclass_q <= IC_NONE;
            rn_q     <= '0;
            rm_q     <= '0;
            rs_q     <= '0;
            list_q   <= '0;
        end else begin
            state_q  <= state_d;
            iclass_q <= iclass_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rs_q     <= rs_d;
            list_q   <= list_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:             if (accept) state_d = (dec_class == IC_BDT) ? ST_BLOCK : ST_SINGLE;
            ST_SINGLE, ST_BLOCK: begin
                if (accept)                    state_d = (dec_class == IC_BDT) ? ST_BLOCK : ST_SINGLE;
                else if (out_ready && out_last) state_d = ST_IDLE;
            end
            default:             state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        iclass_d = iclass_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rs_d     = rs_q;
        list_d   = list_q;
        if (flush) begin
            list_d = '0;
        end else if (accept) begin
            iclass_d = dec_class;
            rn_d     = dec_rn;
            rm_d     = dec_rm;
            rs_d     = dec_rs;
            list_d   = (dec_class == IC_BDT) ? instruction[LIST_W-1:0] : '0;
        end else if (state_q == ST_BLOCK && out_ready) begin
            list_d = list_q & ~enc_onehot;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        rn        = '0;
        rm        = '0;
        rs        = '0;
        iclass    = IC_NONE;
        unique case (state_q)
            ST_SINGLE: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                rn        = rn_q;
                rm        = rm_q;
                rs        = rs_q;
                iclass    = iclass_q;
            end
            ST_BLOCK: begin
                // An empty list still yields one beat, addressing the PC.
                out_valid = 1'b1;
                out_last  = enc_zero || (enc_onehot == list_q);
                rn        = rn_q;
                rs        = enc_zero ? RA_W'(R_PC) : enc_idx;
                iclass    = iclass_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/reg_addr_sequencer.md
REG_ADDR_SEQUENCER -- requirements
Module: reg_addr_sequencer

Interface
REQ-001 SHALL have parameter RA_W, default 4, register-index width.
REQ-002 SHALL have parameter LIST_W, default 16, block-transfer register-list width (≤ 2**RA_W).
REQ-003 SHALL have parameter INSTR_W, default 28, instruction width (condition field excluded).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port instr_valid  input  1  instruction offered.
REQ-007 SHALL have port instr_ready  output  1  sequencer accepts the instruction this cycle.
REQ-008 SHALL have port instruction  input  INSTR_W  instruction bits [27:0].
REQ-009 SHALL have port flush  input  1  abort the current sequence (pipeline flush).
REQ-010 SHALL have port out_valid  output  1  rn/rm/rs beat valid.
REQ-011 SHALL have port out_ready  input  1  register file / downstream consumes the beat.
REQ-012 SHALL have ports rn, rm, rs  output  RA_W each  read-port register indices.
REQ-013 SHALL have port out_last  output  1  final beat of the instruction.
REQ-014 SHALL have port iclass  output  4  decoded instruction class of the current beat.

Function
REQ-015 Classes, checked in this priority order: MUL, MULL, SWP, BX, HDT_REG, HDT_IMM, DP, UNDEF, SDT, BDT, BR, SWI, NONE (bit patterns per the ARM7TDMI encoding tables).
REQ-016 Per-class indices: MUL rn=[15:12], rm=[3:0], rs=[11:8]; MULL rn=[11:8], rm=[3:0], rs=0; SWP rn=[19:16], rm=[3:0], rs=0; BX rn=[3:0], rm=rs=0; HDT_*: rn=[19:16], rm=[3:0], rs=[15:12]; DP: rn=[19:16], rm=[3:0], rs=[11:8]; SDT: rn=[19:16], rm=0, rs=[15:12]; BR: rn=15, rm=rs=0; UNDEF/SWI/NONE: all 0.
REQ-017 Outputs SHALL never be X; every don't-care index SHALL be driven 0.
REQ-018 FSM states: IDLE, SINGLE, BLOCK.
REQ-019 IDLE: instr_ready=1, out_valid=0; on accept, decode is registered; next state is BLOCK for BDT, else SINGLE.
REQ-020 SINGLE: out_valid=1, out_last=1, outputs held stable until out_ready=1.
REQ-021 BLOCK: a remaining-list register SHALL be loaded with [LIST_W-1:0]; each beat rn=[19:16], rm=0, rs=index of the lowest set remaining bit.
REQ-022 BLOCK: on out_ready the lowest set bit SHALL be cleared; out_last=1 when exactly one bit remains.
REQ-023 Empty BDT list SHALL produce one beat with rs=15, out_last=1.
REQ-024 Latency: the first beat SHALL be valid in the cycle after acceptance.
REQ-025 instr_ready SHALL be 1 in IDLE or when out_valid & out_last & out_ready, allowing back-to-back instructions with no bubble.
REQ-026 With out_ready=0, all outputs and the remaining list SHALL hold.
REQ-027 flush=1 SHALL force IDLE next cycle, deassert out_valid and block acceptance that cycle; flush has priority over accept and beat advance.
REQ-028 A new instruction SHALL never be accepted while out_valid=1 and out_last=0.

Reset
REQ-029 reset_n=0 at a clock edge SHALL set state=IDLE, out_valid=0, out_last=0, rn=rm=rs=0, iclass=NONE, remaining list=0, including mid-sequence.
REQ-030 instr_ready SHALL be 0 while reset_n=0.

Structure
REQ-031 Package reg_addr_pkg SHALL hold the iclass enum, the FSM state enum, and constant R_PC=15.
REQ-032 A sub-module lsb_encoder (LIST_W in, RA_W index and one-hot out, zero flag) SHALL provide the lowest-set-bit search.

Verification
REQ-033 LDMIA 0x8928009 accepted, out_ready=1 -> 3 beats rn=2, rs=0,3,15; out_last on beat 3 only.
REQ-034 MUL 0x0010392 -> one beat rn=0, rm=2, rs=3, iclass=MUL, out_last=1; next instruction accepted that same cycle.
REQ-035 BX 0x12FFF1E -> rn=14, rm=0, rs=0, iclass=BX; STM empty list 0x8050000 -> one beat rn=5, rs=15.
REQ-036 LDMIA 0x8928009 with out_ready low for 3 cycles after beat 1 -> rs=0 held 3 cycles, then 3, 15.
REQ-037 flush, then reset_n=0, each asserted during beat 2 of 0x8928009 -> out_valid=0 next cycle, IDLE, instr_ready=1 (after reset release).
